// File: rtl/tag_array_ctrl_if.sv
// Lookup/update request and lookup response bundle between the cache pipeline and tag_array_ctrl.
// Latency: none inside the interface; the response follows a lookup grant by one cycle.
// Backpressure: lkp_ready/upd_ready pulse only in the cycle a request is accepted.
// Ports: lkp_* lookup request, upd_* tag write request, rsp_* lookup result.
interface tag_array_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int TAG_WIDTH  = 21
);
  logic                  lkp_valid;
  logic                  lkp_ready;
  logic [ADDR_WIDTH-1:0] lkp_set;
  logic [TAG_WIDTH-1:0]  lkp_tag;
  logic                  upd_valid;
  logic                  upd_ready;
  logic [ADDR_WIDTH-1:0] upd_set;
  logic [TAG_WIDTH+1:0]  upd_word;
  logic                  rsp_valid;
  logic                  rsp_hit;
  logic                  rsp_dirty;
  logic [TAG_WIDTH-1:0]  rsp_tag;

  // Requester side (cache pipeline / fill engine).
  modport master (
    output lkp_valid, lkp_set, lkp_tag, upd_valid, upd_set, upd_word,
    input  lkp_ready, upd_ready, rsp_valid, rsp_hit, rsp_dirty, rsp_tag
  );

  // Controller side.
  modport slave (
    input  lkp_valid, lkp_set, lkp_tag, upd_valid, upd_set, upd_word,
    output lkp_ready, upd_ready, rsp_valid, rsp_hit, rsp_dirty, rsp_tag
  );
endinterface

// File: rtl/tag_array_ctrl.sv
// Sequencer/arbiter for a single-port tag SRAM: clear sweep after reset/flush, then lookup/update sharing.
// Latency: SRAM access issued in the grant cycle; lookup response valid exactly one cycle later.
// Backpressure: no grants while sweeping or on a flush cycle; contended cycles alternate round-robin.
// Ports: clk/rst, flush_req/busy, tif (lookup/update/response bundle), sram_* to the SRAM RW port.
module tag_array_ctrl #(
  parameter int SETS       = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int TAG_WIDTH  = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  output logic                  busy,
  tag_array_ctrl_if.slave       tif,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [TAG_WIDTH+1:0]  sram_din0,
  input  logic [TAG_WIDTH+1:0]  sram_dout0
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ptr_upd_q, ptr_upd_d;  // 1: update wins the next contended cycle
  logic [ADDR_WIDTH-1:0] addr_q;                 // last driven SRAM address, held when idle
  logic [TAG_WIDTH+1:0]  din_q;                  // last driven SRAM write data, held when idle
  logic [TAG_WIDTH-1:0]  lkp_tag_q;
  logic                  rsp_valid_q;
  logic                  grant_upd, grant_lkp;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_upd_d     = ptr_upd_q;
    busy          = 1'b1;
    tif.lkp_ready = 1'b0;
    tif.upd_ready = 1'b0;
    grant_upd     = 1'b0;
    grant_lkp     = 1'b0;
    sram_csb0     = 1'b1;
    sram_web0     = 1'b1;
    sram_addr0    = addr_q;
    sram_din0     = din_q;

    if (rst) begin
      // Outputs show their reset values for as long as rst is held.
      sram_addr0 = '0;
      sram_din0  = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          sram_csb0  = 1'b0;
          sram_web0  = 1'b0;
          sram_addr0 = cnt_q;
          sram_din0  = '0;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == ADDR_WIDTH'(SETS - 1)) state_d = IDLE;
        end
        IDLE: begin
          busy = 1'b0;
          if (flush_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else begin
            grant_upd = tif.upd_valid && (!tif.lkp_valid || ptr_upd_q);
            grant_lkp = tif.lkp_valid && !grant_upd;
            // Pointer moves only when both sides competed.
            if (tif.upd_valid && tif.lkp_valid) ptr_upd_d = !ptr_upd_q;
            if (grant_upd) begin
              tif.upd_ready = 1'b1;
              sram_csb0     = 1'b0;
              sram_web0     = 1'b0;
              sram_addr0    = tif.upd_set;
              sram_din0     = tif.upd_word;
            end
            if (grant_lkp) begin
              tif.lkp_ready = 1'b1;
              sram_csb0     = 1'b0;
              sram_addr0    = tif.lkp_set;
            end
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      ptr_upd_q   <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      lkp_tag_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_upd_q   <= ptr_upd_d;
      addr_q      <= sram_addr0;
      din_q       <= sram_din0;
      rsp_valid_q <= grant_lkp;
      if (grant_lkp) lkp_tag_q <= tif.lkp_tag;
    end
  end

  // The SRAM returns the word the cycle after the read, so the compare uses the registered tag.
  assign tif.rsp_valid = rsp_valid_q && !rst;
  assign tif.rsp_dirty = sram_dout0[TAG_WIDTH];
  assign tif.rsp_tag   = sram_dout0[TAG_WIDTH-1:0];
  assign tif.rsp_hit   = sram_dout0[TAG_WIDTH+1] && (sram_dout0[TAG_WIDTH-1:0] == lkp_tag_q);

endmodule
